turfio_cin_lock_multi: RTL and testbench

TURFIO_CIN_LOCK_MULTI -- requirements
Module: turfio_cin_lock_multi

---
 rtl/turfio_cin_lock_multi.sv | 147 ++++++++++++++
 tb/tb_turfio_cin_lock_multi.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turfio_cin_lock_multi.sv
// Multi-lane CIN nibble deserializer with training-pattern word alignment.
// Each lane hunts for TRAIN_PATTERN by slipping its word boundary, then locks and streams words.
module turfio_cin_lock_multi #(
    parameter int          NLANES        = 1,
    parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
    parameter int          LOCK_COUNT    = 4,
    parameter int          MAX_SLIPS     = 16,
    parameter int          ERR_W         = 16
) (
    input  logic                    aclk_i,
    input  logic                    rst_i,
    input  logic [4*NLANES-1:0]     cin_i,
    input  logic                    cin_valid_i,
    input  logic [NLANES-1:0]       lock_req_i,
    input  logic [NLANES-1:0]       lock_rst_i,
    input  logic [NLANES-1:0]       bitslip_i,
    input  logic                    check_en_i,
    output logic [NLANES-1:0]       locked_o,
    output logic [NLANES-1:0]       fail_o,
    output logic [32*NLANES-1:0]    cin_parallel_o,
    output logic [NLANES-1:0]       cin_parallel_valid_o,
    output logic [ERR_W*NLANES-1:0] err_cnt_o
);

    typedef enum logic [1:0] {S_UNLOCKED, S_HUNT, S_LOCKED, S_FAIL} state_t;

    localparam logic [7:0] LAST_MATCH = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] SLIP_LIMIT = 8'(MAX_SLIPS);

    for (genvar n = 0; n < NLANES; n++) begin : g_lane
        state_t           r_state;
        logic [31:0]      r_sr;
        logic [2:0]       r_phase;
        logic [7:0]       r_match;
        logic [7:0]       r_slips;
        logic             r_slip_pend;
        logic [ERR_W-1:0] r_err;
        logic             r_locked;
        logic             r_fail;
        logic [31:0]      r_par_p1;
        logic             r_vld_p1;

        logic [3:0]       w_nib;
        logic [31:0]      w_word;
        logic             w_bnd;
        logic             w_hit;
        logic             w_hold;
        logic             w_lrst;

        assign w_nib  = cin_i[4*n +: 4];
        assign w_word = {r_sr[27:0], w_nib};
        assign w_bnd  = cin_valid_i && (r_phase == 3'd7);
        assign w_hit  = (w_word == TRAIN_PATTERN);
        assign w_lrst = lock_rst_i[n];
        // A lock_rst cancels a pending slip before it can hold the phase.
        assign w_hold = r_slip_pend && !w_lrst;

        always_ff @(posedge aclk_i) begin
            if (rst_i) begin
                r_state     <= S_UNLOCKED;
                r_sr        <= '0;
                r_phase     <= '0;
                r_match     <= '0;
                r_slips     <= '0;
                r_slip_pend <= 1'b0;
                r_err       <= '0;
                r_locked    <= 1'b0;
                r_fail      <= 1'b0;
                r_par_p1    <= '0;
                r_vld_p1    <= 1'b0;
            end else begin
                r_vld_p1 <= 1'b0;
                if (cin_valid_i) begin
                    r_sr        <= w_word;
                    r_slip_pend <= 1'b0;
                    if (!w_hold) begin
                        r_phase <= r_phase + 3'd1;
                    end
                end
                if (w_lrst) begin
                    r_state     <= S_UNLOCKED;
                    r_match     <= '0;
                    r_slips     <= '0;
                    r_slip_pend <= 1'b0;
                    r_err       <= '0;
                    r_locked    <= 1'b0;
                    r_fail      <= 1'b0;
                end else begin
                    unique case (r_state)
                        S_UNLOCKED: begin
                            if (lock_req_i[n]) begin
                                r_state <= S_HUNT;
                                r_match <= '0;
                                r_slips <= '0;
                            end
                            if (bitslip_i[n]) begin
                                r_slip_pend <= 1'b1;
                            end
                        end
                        S_HUNT: begin
                            if (w_bnd) begin
                                if (w_hit) begin
                                    if (r_match == LAST_MATCH) begin
                                        r_state  <= S_LOCKED;
                                        r_locked <= 1'b1;
                                        r_err    <= '0;
                                    end else begin
                                        r_match <= r_match + 8'd1;
                                    end
                                end else begin
                                    r_match <= '0;
                                    if (r_slips == SLIP_LIMIT) begin
                                        r_state <= S_FAIL;
                                        r_fail  <= 1'b1;
                                    end else begin
                                        r_slip_pend <= 1'b1;
                                        r_slips     <= r_slips + 8'd1;
                                    end
                                end
                            end
                        end
                        S_LOCKED: begin
                            // boundary word -> output stage (p1)
                            if (w_bnd) begin
                                r_par_p1 <= w_word;
                                r_vld_p1 <= 1'b1;
                                if (check_en_i && !w_hit && !(&r_err)) begin
                                    r_err <= r_err + 1'b1;
                                end
                            end
                        end
                        S_FAIL: begin
                            r_fail <= 1'b1;
                        end
                    endcase
                end
            end
        end

        assign locked_o[n]                   = r_locked;
        assign fail_o[n]                     = r_fail;
        assign cin_parallel_o[32*n +: 32]    = r_par_p1;
        assign cin_parallel_valid_o[n]       = r_vld_p1;
        assign err_cnt_o[ERR_W*n +: ERR_W]   = r_err;
    end

endmodule

// File: tb/tb_turfio_cin_lock_multi.sv
// Bench for turfio_cin_lock_multi: directed scenarios plus random traffic,
// all checked cycle by cycle against a beat-indexed reference model.
module tb_turfio_cin_lock_multi;
    localparam int          NL      = 4;
    localparam int          LC      = 4;
    localparam int          MS      = 16;
    localparam int          EW      = 2;
    localparam int          CW      = 4 * NL;
    localparam logic [31:0] TP      = 32'hA55A6996;
    localparam int          ERR_MAX = (1 << EW) - 1;
    localparam int          M_UNL = 0, M_HUNT = 1, M_LOCK = 2, M_FAIL = 3;

    logic                 aclk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [CW-1:0]        cin_i = '0;
    logic                 cin_valid_i = 1'b0;
    logic [NL-1:0]        lock_req_i = '0;
    logic [NL-1:0]        lock_rst_i = '0;
    logic [NL-1:0]        bitslip_i = '0;
    logic                 check_en_i = 1'b0;
    logic [NL-1:0]        locked_o;
    logic [NL-1:0]        fail_o;
    logic [32*NL-1:0]     cin_parallel_o;
    logic [NL-1:0]        cin_parallel_valid_o;
    logic [EW*NL-1:0]     err_cnt_o;

    always #5 aclk_i = ~aclk_i;

    turfio_cin_lock_multi #(
        .NLANES(NL), .TRAIN_PATTERN(TP), .LOCK_COUNT(LC), .MAX_SLIPS(MS), .ERR_W(EW)
    ) dut (
        .aclk_i(aclk_i), .rst_i(rst_i), .cin_i(cin_i), .cin_valid_i(cin_valid_i),
        .lock_req_i(lock_req_i), .lock_rst_i(lock_rst_i), .bitslip_i(bitslip_i),
        .check_en_i(check_en_i), .locked_o(locked_o), .fail_o(fail_o),
        .cin_parallel_o(cin_parallel_o), .cin_parallel_valid_o(cin_parallel_valid_o),
        .err_cnt_o(err_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: absolute beat count per lane and the beat index of the next boundary.
    int          m_st[NL], m_match[NL], m_slips[NL], m_k[NL], m_nb[NL], m_err[NL];
    bit          m_pend[NL];
    logic [3:0]  m_hist[NL][8];
    bit          e_locked[NL], e_fail[NL], e_pvld[NL];
    logic [31:0] e_par[NL];

    // Stream generator: pattern delayed by g_off nibbles, zero fill before it.
    int g_beat[NL], g_off[NL], g_corrupt[NL];
    bit g_zero = 1'b0;
    int cyc = 0;
    int first_lock[NL], first_fail[NL];

    task automatic model_step();
        logic [31:0] w;
        bit bnd, hold, hit;
        for (int n = 0; n < NL; n++) begin
            if (rst_i) begin
                m_st[n] = M_UNL; m_match[n] = 0; m_slips[n] = 0; m_k[n] = 0; m_nb[n] = 7;
                m_err[n] = 0; m_pend[n] = 0;
                e_locked[n] = 0; e_fail[n] = 0; e_pvld[n] = 0; e_par[n] = '0;
                for (int i = 0; i < 8; i++) m_hist[n][i] = '0;
            end else begin
                e_pvld[n] = 0;
                bnd = 0;
                w = '0;
                if (cin_valid_i) begin
                    m_hist[n][m_k[n] % 8] = cin_i[4*n +: 4];
                    for (int i = 0; i < 8; i++) w = {w[27:0], m_hist[n][(m_k[n] + 1 + i) % 8]};
                    bnd  = (m_k[n] == m_nb[n]);
                    hold = m_pend[n] && !lock_rst_i[n];
                    if (bnd) m_nb[n] = m_k[n] + (hold ? 1 : 8);
                    else if (hold) m_nb[n] = m_nb[n] + 1;
                    m_k[n]++;
                    m_pend[n] = 0;
                end
                hit = (w == TP);
                if (lock_rst_i[n]) begin
                    m_st[n] = M_UNL; m_match[n] = 0; m_slips[n] = 0; m_err[n] = 0; m_pend[n] = 0;
                    e_locked[n] = 0; e_fail[n] = 0;
                end else if (m_st[n] == M_UNL) begin
                    if (lock_req_i[n]) begin
                        m_st[n] = M_HUNT; m_match[n] = 0; m_slips[n] = 0;
                    end
                    if (bitslip_i[n]) m_pend[n] = 1;
                end else if (m_st[n] == M_HUNT && bnd) begin
                    if (hit) begin
                        m_match[n]++;
                        if (m_match[n] == LC) begin
                            m_st[n] = M_LOCK; e_locked[n] = 1; m_err[n] = 0;
                        end
                    end else begin
                        m_match[n] = 0;
                        if (m_slips[n] == MS) begin
                            m_st[n] = M_FAIL; e_fail[n] = 1;
                        end else begin
                            m_pend[n] = 1; m_slips[n]++;
                        end
                    end
                end else if (m_st[n] == M_LOCK && bnd) begin
                    e_par[n] = w;
                    e_pvld[n] = 1;
                    if (check_en_i && !hit && m_err[n] < ERR_MAX) m_err[n]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int n = 0; n < NL; n++) begin
            check_eq($sformatf("locked%0d", n), 64'(locked_o[n]), 64'(e_locked[n]));
            check_eq($sformatf("fail%0d", n), 64'(fail_o[n]), 64'(e_fail[n]));
            check_eq($sformatf("pvld%0d", n), 64'(cin_parallel_valid_o[n]), 64'(e_pvld[n]));
            check_eq($sformatf("par%0d", n), 64'(cin_parallel_o[32*n +: 32]), 64'(e_par[n]));
            check_eq($sformatf("err%0d", n), 64'(err_cnt_o[EW*n +: EW]), 64'(m_err[n]));
        end
    endtask

    task automatic gen(input int n, output logic [3:0] nib);
        int rel, j;
        logic [31:0] tpv;
        tpv = TP;
        rel = g_beat[n] - g_off[n];
        if (g_zero || rel < 0) begin
            nib = 4'h0;
        end else begin
            j = rel % 8;
            nib = tpv[31 - 4*j -: 4];
            if (j == 0 && g_corrupt[n] > 0) begin
                nib = nib ^ 4'h1;
                g_corrupt[n]--;
            end
        end
        g_beat[n]++;
    endtask

    task automatic tick(input bit v, input logic [NL-1:0] lreq, input logic [NL-1:0] lrst,
                        input logic [NL-1:0] bsl, input bit r);
        logic [3:0] nb;
        cin_valid_i = v;
        lock_req_i  = lreq;
        lock_rst_i  = lrst;
        bitslip_i   = bsl;
        rst_i       = r;
        if (v) begin
            for (int n = 0; n < NL; n++) begin
                gen(n, nb);
                cin_i[4*n +: 4] = nb;
            end
        end else begin
            cin_i = CW'($urandom);
        end
        @(posedge aclk_i);
        model_step();
        @(negedge aclk_i);
        compare_all();
        for (int n = 0; n < NL; n++) begin
            if (locked_o[n] && first_lock[n] < 0) first_lock[n] = cyc;
            if (fail_o[n] && first_fail[n] < 0) first_fail[n] = cyc;
        end
        cyc++;
        lock_req_i = '0;
        lock_rst_i = '0;
        bitslip_i  = '0;
        rst_i      = 1'b0;
    endtask

    task automatic clear_marks();
        cyc = 0;
        for (int n = 0; n < NL; n++) begin
            first_lock[n] = -1;
            first_fail[n] = -1;
        end
    endtask

    task automatic start_run(input bit zero);
        g_zero = zero;
        for (int n = 0; n < NL; n++) begin
            g_beat[n] = 0;
            g_corrupt[n] = 0;
        end
        tick(1'b0, '0, '0, '0, 1'b1);
        clear_marks();
    endtask

    initial begin
        int cnt;
        int offs[NL];

        // Lane offsets 0/1/2/7: lock after 0/1/2/7 slips, first lock at beat 31+9*slips
        offs = '{0, 1, 2, 7};
        for (int n = 0; n < NL; n++) g_off[n] = offs[n];
        start_run(1'b0);
        check_eq("rst_locked", 64'(locked_o), 64'(0));
        check_eq("rst_fail", 64'(fail_o), 64'(0));
        check_eq("rst_par", 64'(cin_parallel_o[63:0]), 64'(0));
        check_eq("rst_err", 64'(err_cnt_o), 64'(0));
        tick(1'b1, '1, '0, '0, 1'b0);
        repeat (119) tick(1'b1, '0, '0, '0, 1'b0);
        for (int n = 0; n < NL; n++)
            check_eq($sformatf("lock_time%0d", n), 64'(first_lock[n]), 64'(31 + 9*offs[n]));
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick(1'b1, '0, '0, '0, 1'b0);
            cnt += int'(cin_parallel_valid_o[0]);
        end
        check_eq("pvld_rate", 64'(cnt), 64'(10));
        check_eq("par_word0", 64'(cin_parallel_o[31:0]), 64'(TP));

        // Constant-zero input: 16 slips, fail on the 17th mismatch at beat 151
        start_run(1'b1);
        tick(1'b1, '1, '0, '0, 1'b0);
        repeat (179) tick(1'b1, '0, '0, '0, 1'b0);
        for (int n = 0; n < NL; n++)
            check_eq($sformatf("fail_time%0d", n), 64'(first_fail[n]), 64'(151));
        check_eq("fail_nolock", 64'(locked_o), 64'(0));

        // Error counter saturation with ERR_W=2
        for (int n = 0; n < NL; n++) g_off[n] = 0;
        start_run(1'b0);
        check_en_i = 1'b1;
        tick(1'b1, '1, '0, '0, 1'b0);
        repeat (39) tick(1'b1, '0, '0, '0, 1'b0);
        g_corrupt[0] = 3;
        repeat (40) tick(1'b1, '0, '0, '0, 1'b0);
        check_eq("err_three", 64'(err_cnt_o[EW-1:0]), 64'(3));
        check_eq("err_other", 64'(err_cnt_o[2*EW-1:EW]), 64'(0));
        g_corrupt[0] = 2;
        repeat (30) tick(1'b1, '0, '0, '0, 1'b0);
        check_eq("err_sat", 64'(err_cnt_o[EW-1:0]), 64'(3));

        // lock_rst and lock_req together on a locked lane
        tick(1'b1, 4'b0001, 4'b0001, '0, 1'b0);
        check_eq("lrst_unlock", 64'(locked_o[0]), 64'(0));
        check_eq("lrst_err", 64'(err_cnt_o[EW-1:0]), 64'(0));
        check_eq("lrst_others", 64'(locked_o[NL-1:1]), 64'(3'b111));
        repeat (40) tick(1'b1, '0, '0, '0, 1'b0);
        check_eq("lrst_nohunt", 64'(locked_o[0]), 64'(0));
        check_en_i = 1'b0;

        // Reset during hunt with a slip pending
        for (int n = 0; n < NL; n++) g_off[n] = 3;
        start_run(1'b0);
        tick(1'b1, '1, '0, '0, 1'b0);
        repeat (7) tick(1'b1, '0, '0, '0, 1'b0);
        tick(1'b1, '0, '0, '0, 1'b1);
        check_eq("hrst_locked", 64'(locked_o), 64'(0));
        check_eq("hrst_fail", 64'(fail_o), 64'(0));
        check_eq("hrst_pvld", 64'(cin_parallel_valid_o), 64'(0));
        check_eq("hrst_err", 64'(err_cnt_o), 64'(0));
        clear_marks();
        tick(1'b1, '1, '0, '0, 1'b0);
        repeat (99) tick(1'b1, '0, '0, '0, 1'b0);
        for (int n = 0; n < NL; n++)
            check_eq($sformatf("hrst_lock%0d", n), 64'(first_lock[n]), 64'(49));

        // Random traffic against the model
        for (int n = 0; n < NL; n++) g_off[n] = int'($urandom_range(0, 7));
        start_run(1'b0);
        for (int i = 0; i < 4000; i++) begin
            logic [NL-1:0] lq, lr, bs;
            if (i % 64 == 0) check_en_i = $urandom_range(0, 1) == 1;
            for (int n = 0; n < NL; n++) begin
                lq[n] = ($urandom % 30) == 0;
                lr[n] = ($urandom % 250) == 0;
                bs[n] = ($urandom % 25) == 0;
                if (($urandom % 60) == 0) g_corrupt[n]++;
            end
            tick(($urandom % 4) != 0, lq, lr, bs, ($urandom % 600) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
